updown_load_counter: RTL

Parametrised loadable up/down counter: the next generation of the 4-bit load counter. It adds configurable width, a programmable modulus, a count enable, direction control, wrap/saturate mode, a terminal-count flag, a wrap pulse and protection against out-of-range loads. It is the general counter used by timers, address generators and tick dividers in the design.

---
 rtl/updown_load_counter.sv | 77 +++++++
 1 files changed

// File: rtl/updown_load_counter.sv
// Loadable up/down counter with programmable modulus, wrap or saturate limit
// behaviour, terminal-count flag, and single-cycle wrap / load-clamp pulses.
module updown_load_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             up_dn_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             wrap_o,
  output logic             load_err_o
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             load_err_nxt;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (count_o == MAX_CNT);
  assign at_zero = (count_o == '0);

  // Limits are set by MAX_CNT, so binary overflow never decides a wrap.
  always_comb begin
    count_nxt    = count_o;
    wrap_nxt     = 1'b0;
    load_err_nxt = 1'b0;
    if (load_i) begin
      if (load_val_i > MAX_CNT) begin
        count_nxt    = MAX_CNT;
        load_err_nxt = 1'b1;
      end else begin
        count_nxt = load_val_i;
      end
    end else if (en_i) begin
      if (up_dn_i) begin
        if (!at_max) begin
          count_nxt = count_o + ONE;
        end else if (!SATURATE) begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_nxt = count_o - ONE;
        end else if (!SATURATE) begin
          count_nxt = MAX_CNT;
          wrap_nxt  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_o    <= '0;
      wrap_o     <= 1'b0;
      load_err_o <= 1'b0;
    end else begin
      count_o    <= count_nxt;
      wrap_o     <= wrap_nxt;
      load_err_o <= load_err_nxt;
    end
  end

  assign tc_o = up_dn_i ? at_max : at_zero;

endmodule
